lock_relock_fsm: RTL and testbench
==================================

LOCK_RELOCK_FSM -- requirements
Module: lock_relock_fsm

Interface
REQ-001 SHALL have parameter RW, default 14, data width of the PID output, error, thresholds and sweep values.
REQ-002 SHALL have parameter CW, default 16, width of the hold and settle counters.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port rstn_i, input, 1: synchronous, active-high reset; the port keeps the codebase's existing name despite the "n".
REQ-005 SHALL have port enable_i, input, 1: relock supervision enable.
REQ-006 SHALL have port pid_dat_i, input, RW signed: PID block output.
REQ-007 SHALL have port sig_i, input, RW signed: lock-quality signal, e.g. demodulated amplitude.
REQ-008 SHALL have ports out_hi_i and out_lo_i, input, RW signed: allowed window for the PID output.
REQ-009 SHALL have port sig_min_i, input, RW signed: minimum sig_i that counts as locked.
REQ-010 SHALL have ports hold_cnt_i and settle_cnt_i, input, CW: hold cycles before declaring unlock, and settle cycles before declaring lock.
REQ-011 SHALL have ports swp_lo_i and swp_hi_i, input, RW signed: sweep limits.
REQ-012 SHALL have port swp_step_i, input, RW-1 unsigned: sweep increment per tick.
REQ-013 SHALL have port swp_div_i, input, CW: sweep prescaler; one tick every swp_div_i+1 cycles.
REQ-014 SHALL have port dat_o, output, RW signed: actuator value.
REQ-015 SHALL have ports int_rst_o and pid_ifreeze_o, output, 1: drive int_rst_i and pid_ifreeze of the PID block.
REQ-016 SHALL have port int_rst_val_o, output, RW signed: integrator reload value.
REQ-017 SHALL have ports state_o (output, 2), locked_o (output, 1) and relock_cnt_o (output, 8): FSM state, lock flag and relock event count.

Function
REQ-018 SHALL implement the states IDLE=0, LOCKED=1, SEARCH=2 and ACQUIRE=3.
REQ-019 SHALL move from any state to IDLE on the next edge when enable_i=0; IDLE SHALL move to LOCKED when enable_i=1.
REQ-020 SHALL define the fault condition as: pid_dat_i>out_hi_i, or pid_dat_i<out_lo_i, or sig_i<sig_min_i (all signed compares).
REQ-021 In LOCKED, the hold counter SHALL increment while fault is true and clear to 0 when fault is false.
REQ-022 LOCKED SHALL move to SEARCH when fault is true and count+1 >= max(hold_cnt_i,1); relock_cnt_o SHALL then increment, saturating at 255.
REQ-023 On entry to SEARCH, the sweep register SHALL load pid_dat_i clamped to [swp_lo_i, swp_hi_i], with direction up.
REQ-024 In SEARCH, each tick SHALL add or subtract swp_step_i in RW+1-bit signed arithmetic.
REQ-025 If the SEARCH result passes a limit, the sweep SHALL clamp to that limit and reverse direction; a step landing exactly on a limit SHALL also reverse.
REQ-026 If swp_hi_i<=swp_lo_i, the sweep SHALL hold at swp_lo_i; if swp_step_i=0, the sweep SHALL stay stationary.
REQ-027 SEARCH SHALL move to ACQUIRE when sig_i>=sig_min_i; on that edge int_rst_val_o SHALL take the current sweep value.
REQ-028 In ACQUIRE, the settle counter SHALL count cycles with sig_i>=sig_min_i.
REQ-029 In ACQUIRE, sig_i<sig_min_i SHALL return the FSM to SEARCH, resuming from the held sweep value and direction, without a relock_cnt_o increment.
REQ-030 ACQUIRE SHALL move to LOCKED when the settle count reaches max(settle_cnt_i,1).
REQ-031 All outputs SHALL be registered, decoded from the next state, so they are valid on the same edge as the state change.
REQ-032 Output decode: IDLE, LOCKED and ACQUIRE drive dat_o=pid_dat_i (one-cycle latency); SEARCH drives dat_o=sweep value.
REQ-033 int_rst_o=1 and pid_ifreeze_o=1 SHALL hold only in SEARCH.
REQ-034 locked_o=1 SHALL hold only in LOCKED.
REQ-035 The prescaler SHALL reset to 0 on entry to SEARCH, so the first tick occurs swp_div_i+1 cycles after entry.
REQ-036 Counters SHALL clear on every state change.

Reset
REQ-037 With rstn_i=1 the block SHALL go to state IDLE and drive dat_o=0, int_rst_o=0, pid_ifreeze_o=0, int_rst_val_o=0, locked_o=0 and relock_cnt_o=0.
REQ-038 Reset SHALL also clear all counters, the sweep register and direction; reset during SEARCH SHALL abort the sweep with no residual state.

Structure
REQ-039 State encoding, RW/CW defaults and the relock-count width SHALL live in shared package lock_pkg.
REQ-040 The triangle sweep (prescaler, step, clamp, reverse) SHALL be sub-module lock_sweep_gen, with load, run, init and value/direction outputs.

Verification
REQ-041 Window [-4000,4000], hold=10; pid_dat_i=5000 for 10 cycles -> SEARCH on the 10th edge, int_rst_o=1, relock_cnt_o=1; 9 cycles then a clean cycle -> stays LOCKED.
REQ-042 Sweep lo=-100, hi=100, step=30, div=0, entry at pid=5000 -> dat_o 100, 70, 40, ..., -80, -100, -70.
REQ-043 In SEARCH, set sig_i>=sig_min_i at sweep=40 -> ACQUIRE, int_rst_val_o=40, ifreeze=0; settle=5 clean cycles -> LOCKED, locked_o=1.
REQ-044 Drop sig_i in ACQUIRE cycle 3 -> SEARCH resumes from 40 in the same direction; relock_cnt_o unchanged.
REQ-045 Drive enable_i=0 mid-SEARCH, then assert rstn_i mid-SEARCH -> IDLE next edge, int_rst_o=0, dat_o follows pid_dat_i; after reset all outputs are 0.
REQ-046 Force 300 unlock events -> relock_cnt_o saturates at 255.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the lock supervisor: state encoding, default widths and the
// relock counter width.
package lock_pkg;

    localparam int unsigned RwDefault  = 14;
    localparam int unsigned CwDefault  = 16;
    localparam int unsigned RelockCntW = 8;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLocked  = 2'd1,
        StSearch  = 2'd2,
        StAcquire = 2'd3
    } lock_state_e;

endpackage

// File: rtl/lock_sweep_gen.sv
// Triangle sweep generator: prescaled ticks step a value between two limits,
// clamping and reversing at each end.
module lock_sweep_gen
    import lock_pkg::*;
#(
    parameter int unsigned RW = RwDefault,
    parameter int unsigned CW = CwDefault
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 load_i,
    input  logic                 init_i,
    input  logic                 run_i,
    input  logic signed [RW-1:0] load_val_i,
    input  logic signed [RW-1:0] lo_i,
    input  logic signed [RW-1:0] hi_i,
    input  logic        [RW-2:0] step_i,
    input  logic        [CW-1:0] div_i,
    output logic signed [RW-1:0] val_o,
    output logic signed [RW-1:0] val_nxt_o,
    output logic                 dir_up_o
);

    logic signed [RW-1:0] val_q, val_d;
    logic                 dir_q, dir_d;
    logic        [CW-1:0] presc_q, presc_d;
    logic                 tick;
    logic signed [RW:0]   val_ext, step_ext, lo_ext, hi_ext, sum;

    assign val_ext  = {val_q[RW-1], val_q};
    assign lo_ext   = {lo_i[RW-1], lo_i};
    assign hi_ext   = {hi_i[RW-1], hi_i};
    assign step_ext = $signed({2'b00, step_i});
    assign sum      = dir_q ? (val_ext + step_ext) : (val_ext - step_ext);
    assign tick     = run_i && (presc_q == div_i);

    always_comb begin
        presc_d = presc_q;
        if (load_i || init_i) begin
            presc_d = '0;
        end else if (run_i) begin
            presc_d = tick ? '0 : presc_q + CW'(1);
        end
    end

    always_comb begin
        val_d = val_q;
        dir_d = dir_q;
        if (load_i) begin
            if (hi_i <= lo_i) begin
                val_d = lo_i;
            end else if (load_val_i > hi_i) begin
                val_d = hi_i;
            end else if (load_val_i < lo_i) begin
                val_d = lo_i;
            end else begin
                val_d = load_val_i;
            end
            // A load onto the upper limit counts as landing on it, so head down.
            dir_d = (val_d < hi_i);
        end else if (tick) begin
            if (hi_i <= lo_i) begin
                val_d = lo_i;
            end else if (step_i != '0) begin
                if (dir_q) begin
                    if (sum >= hi_ext) begin
                        val_d = hi_i;
                        dir_d = 1'b0;
                    end else begin
                        val_d = sum[RW-1:0];
                    end
                end else begin
                    if (sum <= lo_ext) begin
                        val_d = lo_i;
                        dir_d = 1'b1;
                    end else begin
                        val_d = sum[RW-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            val_q   <= '0;
            dir_q   <= 1'b0;
            presc_q <= '0;
        end else begin
            val_q   <= val_d;
            dir_q   <= dir_d;
            presc_q <= presc_d;
        end
    end

    assign val_o     = val_q;
    assign val_nxt_o = val_d;
    assign dir_up_o  = dir_q;

endmodule

// File: rtl/lock_relock_fsm.sv
// Lock supervisor: watches a PID loop, sweeps the actuator to reacquire lock when the
// output leaves its window or the lock-quality signal drops, then hands back to the PID.
module lock_relock_fsm
    import lock_pkg::*;
#(
    parameter int unsigned RW = RwDefault,
    parameter int unsigned CW = CwDefault
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  enable_i,
    input  logic signed [RW-1:0]  pid_dat_i,
    input  logic signed [RW-1:0]  sig_i,
    input  logic signed [RW-1:0]  out_hi_i,
    input  logic signed [RW-1:0]  out_lo_i,
    input  logic signed [RW-1:0]  sig_min_i,
    input  logic        [CW-1:0]  hold_cnt_i,
    input  logic        [CW-1:0]  settle_cnt_i,
    input  logic signed [RW-1:0]  swp_lo_i,
    input  logic signed [RW-1:0]  swp_hi_i,
    input  logic        [RW-2:0]  swp_step_i,
    input  logic        [CW-1:0]  swp_div_i,
    output logic signed [RW-1:0]  dat_o,
    output logic                  int_rst_o,
    output logic                  pid_ifreeze_o,
    output logic signed [RW-1:0]  int_rst_val_o,
    output logic        [1:0]     state_o,
    output logic                  locked_o,
    output logic [RelockCntW-1:0] relock_cnt_o
);

    lock_state_e state_q, state_d;

    logic        [CW-1:0]         hold_q, hold_d, settle_q, settle_d;
    logic        [CW:0]           hold_lim, settle_lim, hold_inc, settle_inc;
    logic [RelockCntW-1:0]        relock_q, relock_d;
    logic                         sig_ok, fault;
    logic                         swp_load, swp_init, swp_run;
    logic signed [RW-1:0]         swp_val, swp_nxt;
    logic                         unused_swp_dir;

    logic signed [RW-1:0]         dat_q, dat_d, rst_val_q, rst_val_d;
    logic                         int_rst_q, int_rst_d, freeze_q, freeze_d, locked_q, locked_d;

    assign sig_ok = (sig_i >= sig_min_i);
    assign fault  = (pid_dat_i > out_hi_i) || (pid_dat_i < out_lo_i) || !sig_ok;

    // Limits of zero behave as one so a transition always needs at least one cycle.
    assign hold_lim   = (hold_cnt_i == '0) ? (CW+1)'(1) : {1'b0, hold_cnt_i};
    assign settle_lim = (settle_cnt_i == '0) ? (CW+1)'(1) : {1'b0, settle_cnt_i};
    assign hold_inc   = {1'b0, hold_q} + (CW+1)'(1);
    assign settle_inc = {1'b0, settle_q} + (CW+1)'(1);

    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    state_d = StLocked;
                StLocked:  if (fault && (hold_inc >= hold_lim)) state_d = StSearch;
                StSearch:  if (sig_ok) state_d = StAcquire;
                StAcquire: begin
                    if (!sig_ok) begin
                        state_d = StSearch;
                    end else if (settle_inc >= settle_lim) begin
                        state_d = StLocked;
                    end
                end
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        hold_d   = '0;
        settle_d = '0;
        relock_d = relock_q;
        if (state_d == state_q) begin
            if ((state_q == StLocked) && fault) hold_d = hold_q + CW'(1);
            if ((state_q == StAcquire) && sig_ok) settle_d = settle_q + CW'(1);
        end
        if ((state_q == StLocked) && (state_d == StSearch) && (relock_q != '1)) begin
            relock_d = relock_q + RelockCntW'(1);
        end
    end

    // Only a fresh unlock reloads the sweep; a return from ACQUIRE resumes where it paused.
    assign swp_load = (state_q == StLocked) && (state_d == StSearch);
    assign swp_init = (state_q != StSearch) && (state_d == StSearch);
    assign swp_run  = (state_q == StSearch) && (state_d == StSearch);

    lock_sweep_gen #(
        .RW (RW),
        .CW (CW)
    ) u_sweep (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load_i     (swp_load),
        .init_i     (swp_init),
        .run_i      (swp_run),
        .load_val_i (pid_dat_i),
        .lo_i       (swp_lo_i),
        .hi_i       (swp_hi_i),
        .step_i     (swp_step_i),
        .div_i      (swp_div_i),
        .val_o      (swp_val),
        .val_nxt_o  (swp_nxt),
        .dir_up_o   (unused_swp_dir)
    );

    always_comb begin
        dat_d     = (state_d == StSearch) ? swp_nxt : pid_dat_i;
        int_rst_d = (state_d == StSearch);
        freeze_d  = (state_d == StSearch);
        locked_d  = (state_d == StLocked);
        rst_val_d = rst_val_q;
        if ((state_q == StSearch) && (state_d == StAcquire)) rst_val_d = swp_val;
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            hold_q    <= '0;
            settle_q  <= '0;
            relock_q  <= '0;
            dat_q     <= '0;
            int_rst_q <= 1'b0;
            freeze_q  <= 1'b0;
            locked_q  <= 1'b0;
            rst_val_q <= '0;
        end else begin
            hold_q    <= hold_d;
            settle_q  <= settle_d;
            relock_q  <= relock_d;
            dat_q     <= dat_d;
            int_rst_q <= int_rst_d;
            freeze_q  <= freeze_d;
            locked_q  <= locked_d;
            rst_val_q <= rst_val_d;
        end
    end

    assign dat_o         = dat_q;
    assign int_rst_o     = int_rst_q;
    assign pid_ifreeze_o = freeze_q;
    assign int_rst_val_o = rst_val_q;
    assign locked_o      = locked_q;
    assign relock_cnt_o  = relock_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_lock_relock_fsm.sv
// Directed bench for lock_relock_fsm: hold/unlock, sweep shape, acquire/settle,
// disable and reset aborts, relock counter saturation.
module tb_lock_relock_fsm;

    localparam int unsigned RW = 14;
    localparam int unsigned CW = 16;

    logic                 clk_i = 1'b0;
    logic                 rstn_i;
    logic                 enable_i;
    logic signed [RW-1:0] pid_dat_i, sig_i, out_hi_i, out_lo_i, sig_min_i;
    logic        [CW-1:0] hold_cnt_i, settle_cnt_i, swp_div_i;
    logic signed [RW-1:0] swp_lo_i, swp_hi_i;
    logic        [RW-2:0] swp_step_i;
    logic signed [RW-1:0] dat_o, int_rst_val_o;
    logic                 int_rst_o, pid_ifreeze_o, locked_o;
    logic        [1:0]    state_o;
    logic        [7:0]    relock_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    int sweep_exp [16] = '{70, 40, 10, -20, -50, -80, -100, -70,
                           -40, -10, 20, 50, 80, 100, 70, 40};

    lock_relock_fsm #(
        .RW (RW),
        .CW (CW)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .enable_i      (enable_i),
        .pid_dat_i     (pid_dat_i),
        .sig_i         (sig_i),
        .out_hi_i      (out_hi_i),
        .out_lo_i      (out_lo_i),
        .sig_min_i     (sig_min_i),
        .hold_cnt_i    (hold_cnt_i),
        .settle_cnt_i  (settle_cnt_i),
        .swp_lo_i      (swp_lo_i),
        .swp_hi_i      (swp_hi_i),
        .swp_step_i    (swp_step_i),
        .swp_div_i     (swp_div_i),
        .dat_o         (dat_o),
        .int_rst_o     (int_rst_o),
        .pid_ifreeze_o (pid_ifreeze_o),
        .int_rst_val_o (int_rst_val_o),
        .state_o       (state_o),
        .locked_o      (locked_o),
        .relock_cnt_o  (relock_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_state"}, state_o, 0);
        check_eq({tag, "_dat"}, dat_o, 0);
        check_eq({tag, "_int_rst"}, int_rst_o, 0);
        check_eq({tag, "_ifreeze"}, pid_ifreeze_o, 0);
        check_eq({tag, "_rst_val"}, int_rst_val_o, 0);
        check_eq({tag, "_locked"}, locked_o, 0);
        check_eq({tag, "_relock"}, relock_cnt_o, 0);
    endtask

    initial begin
        rstn_i       = 1'b1;
        enable_i     = 1'b0;
        pid_dat_i    = 123;
        sig_i        = 200;
        out_hi_i     = 4000;
        out_lo_i     = -4000;
        sig_min_i    = 100;
        hold_cnt_i   = 10;
        settle_cnt_i = 5;
        swp_lo_i     = -100;
        swp_hi_i     = 100;
        swp_step_i   = 30;
        swp_div_i    = 0;

        step_n(2);
        check_reset_outputs("reset");

        rstn_i   = 1'b0;
        enable_i = 1'b1;
        step_n(1);
        check_eq("idle_to_locked", state_o, 1);
        check_eq("locked_flag", locked_o, 1);
        check_eq("locked_dat", dat_o, 123);

        // Nine faulty cycles then a clean one must not unlock.
        pid_dat_i = 5000;
        step_n(9);
        check_eq("hold9_state", state_o, 1);
        pid_dat_i = 0;
        step_n(1);
        check_eq("hold_clean_state", state_o, 1);
        check_eq("hold_clean_relock", relock_cnt_o, 0);

        pid_dat_i = 5000;
        sig_i     = 0;
        step_n(9);
        check_eq("hold10_pre", state_o, 1);
        step_n(1);
        check_eq("unlock_state", state_o, 2);
        check_eq("unlock_int_rst", int_rst_o, 1);
        check_eq("unlock_ifreeze", pid_ifreeze_o, 1);
        check_eq("unlock_locked", locked_o, 0);
        check_eq("unlock_relock", relock_cnt_o, 1);
        check_eq("sweep_entry", dat_o, 100);

        for (int i = 0; i < 16; i++) begin
            step_n(1);
            check_eq($sformatf("sweep_%0d", i), dat_o, sweep_exp[i]);
        end

        sig_i = 200;
        step_n(1);
        check_eq("acq_state", state_o, 3);
        check_eq("acq_rst_val", int_rst_val_o, 40);
        check_eq("acq_ifreeze", pid_ifreeze_o, 0);
        check_eq("acq_int_rst", int_rst_o, 0);
        check_eq("acq_dat", dat_o, 5000);

        step_n(2);
        check_eq("acq_hold_state", state_o, 3);
        sig_i = 0;
        step_n(1);
        check_eq("resume_state", state_o, 2);
        check_eq("resume_dat", dat_o, 40);
        check_eq("resume_relock", relock_cnt_o, 1);
        step_n(1);
        check_eq("resume_dir", dat_o, 10);

        sig_i = 200;
        step_n(1);
        check_eq("acq2_state", state_o, 3);
        check_eq("acq2_rst_val", int_rst_val_o, 10);
        pid_dat_i = 0;
        step_n(4);
        check_eq("settle4_state", state_o, 3);
        step_n(1);
        check_eq("settle5_state", state_o, 1);
        check_eq("settle5_locked", locked_o, 1);

        pid_dat_i = 5000;
        sig_i     = 0;
        step_n(10);
        check_eq("unlock2_state", state_o, 2);
        check_eq("unlock2_relock", relock_cnt_o, 2);
        step_n(2);
        check_eq("unlock2_dat", dat_o, 40);

        enable_i  = 1'b0;
        pid_dat_i = 777;
        step_n(1);
        check_eq("disable_state", state_o, 0);
        check_eq("disable_int_rst", int_rst_o, 0);
        check_eq("disable_dat", dat_o, 777);

        enable_i   = 1'b1;
        hold_cnt_i = 1;
        step_n(1);
        check_eq("reen_state", state_o, 1);
        step_n(1);
        check_eq("unlock3_state", state_o, 2);
        check_eq("unlock3_relock", relock_cnt_o, 3);
        step_n(1);
        check_eq("unlock3_dat", dat_o, 70);

        rstn_i = 1'b1;
        step_n(1);
        check_reset_outputs("mid_reset");

        // A fresh sweep after reset must start from the low clamp heading up.
        rstn_i    = 1'b0;
        pid_dat_i = -5000;
        step_n(1);
        check_eq("post_rst_state", state_o, 1);
        check_eq("post_rst_dat", dat_o, -5000);
        step_n(1);
        check_eq("post_rst_sweep0", dat_o, -100);
        check_eq("post_rst_relock", relock_cnt_o, 1);
        step_n(1);
        check_eq("post_rst_sweep1", dat_o, -70);

        sig_i        = 200;
        settle_cnt_i = 1;
        step_n(3);
        check_eq("cycle_state", state_o, 2);
        check_eq("cycle_relock", relock_cnt_o, 2);
        step_n(900);
        check_eq("relock_sat", relock_cnt_o, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
